// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared FSM state encoding and seven-segment constants
package bcd_pkg;

  // Display slot sequence: S_UNITS -> S_GAP0 -> S_TENS -> S_GAP1 -> S_UNITS
  typedef enum logic [1:0] {
    S_UNITS = 2'd0,
    S_GAP0  = 2'd1,
    S_TENS  = 2'd2,
    S_GAP1  = 2'd3
  } state_t;

  // Segment patterns, seg[0]=a .. seg[6]=g, active-high
  localparam logic [6:0] SEG_0   = 7'h3F;
  localparam logic [6:0] SEG_1   = 7'h06;
  localparam logic [6:0] SEG_2   = 7'h5B;
  localparam logic [6:0] SEG_3   = 7'h4F;
  localparam logic [6:0] SEG_4   = 7'h66;
  localparam logic [6:0] SEG_5   = 7'h6D;
  localparam logic [6:0] SEG_6   = 7'h7D;
  localparam logic [6:0] SEG_7   = 7'h07;
  localparam logic [6:0] SEG_8   = 7'h7F;
  localparam logic [6:0] SEG_9   = 7'h6F;
  localparam logic [6:0] SEG_E   = 7'h79;
  localparam logic [6:0] SEG_R   = 7'h50;
  localparam logic [6:0] SEG_OFF = 7'h00;

endpackage

// File: rtl/bcd_to_seg7.sv
// rtl/bcd_to_seg7.sv - combinational BCD digit to seven-segment decoder
// Ports:
//   bcd  in  4  BCD digit; codes above 9 decode to all segments off
//   seg  out 7  segment pattern, seg[0]=a .. seg[6]=g
module bcd_to_seg7
  import bcd_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_OFF;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/bcd_display_mux.sv
// rtl/bcd_display_mux.sv - two-digit multiplexed seven-segment driver with error blink
// Ports:
//   clk       in  1  clock, rising edge
//   rst       in  1  asynchronous active-high reset
//   load      in  1  capture in0/in1/flag
//   in0       in  4  units BCD digit
//   in1       in  4  tens BCD digit
//   flag      in  1  upstream error flag
//   blank_lz  in  1  blank a zero tens digit
//   seg       out 7  shared segment bus, active-high
//   an        out 2  one-hot digit enable (an[0]=units, an[1]=tens)
//   err       out 1  captured error status
module bcd_display_mux
  import bcd_pkg::*;
#(
  parameter int REFRESH_DIV = 4,
  parameter int BLINK_DIV   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       load,
  input  logic [3:0] in0,
  input  logic [3:0] in1,
  input  logic       flag,
  input  logic       blank_lz,
  output logic [6:0] seg,
  output logic [1:0] an,
  output logic       err
);

  localparam int CW = $clog2(REFRESH_DIV) + 1;
  localparam int FW = $clog2(BLINK_DIV) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_DIV - 1);

  state_t        state;
  logic [CW-1:0] cnt;
  logic [FW-1:0] frame_cnt;
  logic          blink_on;
  logic [3:0]    d0;
  logic [3:0]    d1;
  logic          e;

  logic [3:0]    digit_sel;
  logic [6:0]    digit_seg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_GAP1;
      cnt       <= '0;
      frame_cnt <= '0;
      blink_on  <= 1'b1;
      d0        <= 4'd0;
      d1        <= 4'd0;
      e         <= 1'b0;
    end else begin
      if (load) begin
        d0 <= in0;
        d1 <= in1;
        e  <= flag | (in0 > 4'd9) | (in1 > 4'd9);
      end

      case (state)
        S_UNITS: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_GAP0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        S_GAP0: begin
          cnt   <= '0;
          state <= S_TENS;
        end
        S_TENS: begin
          if (cnt == CNT_LAST) begin
            cnt   <= '0;
            state <= S_GAP1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_UNITS;
        end
      endcase

      // A new capture restarts the blink so an error always appears "on" first;
      // load takes priority over a coincident end-of-frame.
      if (load) begin
        frame_cnt <= '0;
        blink_on  <= 1'b1;
      end else if (state == S_GAP1) begin
        if (frame_cnt == FRM_LAST) begin
          frame_cnt <= '0;
          blink_on  <= ~blink_on;
        end else begin
          frame_cnt <= frame_cnt + FW'(1);
        end
      end
    end
  end

  // One shared decoder; the tens digit is only routed in during S_TENS
  assign digit_sel = (state == S_TENS) ? d1 : d0;

  bcd_to_seg7 u_dec (
    .bcd (digit_sel),
    .seg (digit_seg)
  );

  always_comb begin
    seg = SEG_OFF;
    an  = 2'b00;
    case (state)
      S_UNITS: begin
        if (e) begin
          if (blink_on) begin
            an  = 2'b01;
            seg = SEG_R;
          end
        end else begin
          an  = 2'b01;
          seg = digit_seg;
        end
      end
      S_TENS: begin
        if (e) begin
          if (blink_on) begin
            an  = 2'b10;
            seg = SEG_E;
          end
        end else if (!(blank_lz && (d1 == 4'd0))) begin
          an  = 2'b10;
          seg = digit_seg;
        end
      end
      default: begin
        seg = SEG_OFF;
        an  = 2'b00;
      end
    endcase
  end

  assign err = e;

endmodule

// File: tb/tb_bcd_display_mux.sv
// tb/tb_bcd_display_mux.sv - self-checking bench for bcd_display_mux
module tb_bcd_display_mux;

  localparam int R  = 4;
  localparam int BD = 2;
  localparam int F  = 2 * R + 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       load = 1'b0;
  logic [3:0] in0 = 4'd0;
  logic [3:0] in1 = 4'd0;
  logic       flag = 1'b0;
  logic       blank_lz = 1'b0;
  logic [6:0] seg;
  logic [1:0] an;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;
  logic check_en = 1'b0;

  bcd_display_mux #(.REFRESH_DIV(R), .BLINK_DIV(BD)) dut (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .in0      (in0),
    .in1      (in1),
    .flag     (flag),
    .blank_lz (blank_lz),
    .seg      (seg),
    .an       (an),
    .err      (err)
  );

  always #5 clk = ~clk;

  // Behavioural model: position within the frame, frames since last capture,
  // and the captured values.
  logic [6:0] seg_tab [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};
  int         mpos = F - 1;
  int         mframes = 0;
  int         md0 = 0;
  int         md1 = 0;
  logic       me = 1'b0;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mpos = F - 1; mframes = 0; md0 = 0; md1 = 0; me = 1'b0;
    end else begin
      mpos = (mpos + 1) % F;
      if (load) begin
        md0 = int'(in0); md1 = int'(in1);
        me = flag || (in0 > 9) || (in1 > 9);
        mframes = 0;
      end else if (mpos == 0) begin
        mframes++;
      end
    end
  end

  function automatic void model_out(output logic [6:0] s, output logic [1:0] a);
    logic blink_off;
    blink_off = me && (((mframes / BD) % 2) == 1);
    s = 7'h00; a = 2'b00;
    if (blink_off) begin
      s = 7'h00; a = 2'b00;
    end else if (mpos < R) begin
      a = 2'b01;
      s = me ? 7'h50 : seg_tab[md0];
    end else if (mpos >= R + 1 && mpos <= 2 * R) begin
      if (me) begin
        a = 2'b10; s = 7'h79;
      end else if (!(blank_lz && md1 == 0)) begin
        a = 2'b10; s = seg_tab[md1];
      end
    end
  endfunction

  always @(negedge clk) begin
    logic [6:0] es;
    logic [1:0] ea;
    if (check_en) begin
      model_out(es, ea);
      n_cmp++;
      if (seg !== es || an !== ea || err !== me) begin
        n_bad++;
        $display("FAIL cycle_check t=%0t got seg=%h an=%b err=%b want seg=%h an=%b err=%b",
                 $time, seg, an, err, es, ea, me);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic do_load(input logic [3:0] u, input logic [3:0] t, input logic f);
    in0 = u; in1 = t; flag = f; load = 1'b1;
    cyc();
    load = 1'b0;
  endtask

  task automatic window(input int n, input logic [6:0] us, input logic [6:0] ts,
                        output int cu, output int ct, output int cz);
    cu = 0; ct = 0; cz = 0;
    for (int i = 0; i < n; i++) begin
      if (an == 2'b01 && seg == us) cu++;
      if (an == 2'b10 && seg == ts) ct++;
      if (an == 2'b00 && seg == 7'h00) cz++;
      cyc();
    end
  endtask

  // Leaves the bench in the S_GAP1 cycle that follows a lit tens slot
  task automatic find_gap1(input string name);
    int k = 0;
    while (an != 2'b10 && k < 100) begin cyc(); k++; end
    while (an != 2'b00 && k < 100) begin cyc(); k++; end
    chk(name, int'(k < 100), 1);
  endtask

  initial begin
    int cu, ct, cz, k;
    #1 rst = 1'b1;
    #2;
    chk("reset_seg", int'(seg), 0);
    chk("reset_an", int'(an), 0);
    chk("reset_err", int'(err), 0);
    cyc();
    rst = 1'b0;
    check_en = 1'b1;
    cyc();
    chk("first_an", int'(an), 1);
    chk("first_seg", int'(seg), 'h3F);

    do_load(4'd7, 4'd1, 1'b0);
    chk("load17_err", int'(err), 0);
    window(F, 7'h07, 7'h06, cu, ct, cz);
    chk("load17_units", cu, 4);
    chk("load17_tens", ct, 4);
    chk("load17_gaps", cz, 2);

    blank_lz = 1'b1;
    do_load(4'd5, 4'd0, 1'b0);
    window(F, 7'h6D, 7'h3F, cu, ct, cz);
    chk("blank_units", cu, 4);
    chk("blank_tens", ct, 0);
    chk("blank_off", cz, 6);
    blank_lz = 1'b0;
    window(F, 7'h6D, 7'h3F, cu, ct, cz);
    chk("noblank_tens", ct, 4);

    find_gap1("align_flag");
    do_load(4'd3, 4'd2, 1'b1);
    chk("flag_err", int'(err), 1);
    window(2 * F, 7'h50, 7'h79, cu, ct, cz);
    chk("flag_on_r", cu, 8);
    chk("flag_on_e", ct, 8);
    chk("flag_on_gaps", cz, 4);
    window(2 * F, 7'h50, 7'h79, cu, ct, cz);
    chk("flag_off", cz, 2 * F);

    find_gap1("align_hex");
    do_load(4'hC, 4'd0, 1'b0);
    chk("hex_err", int'(err), 1);
    window(2 * F, 7'h50, 7'h79, cu, ct, cz);
    chk("hex_on_r", cu, 8);
    chk("hex_on_e", ct, 8);
    chk("hex_on_gaps", cz, 4);
    window(2 * F, 7'h50, 7'h79, cu, ct, cz);
    chk("hex_off", cz, 2 * F);

    k = 0;
    while (an != 2'b10 && k < 100) begin cyc(); k++; end
    chk("align_rst", int'(k < 100), 1);
    #1 rst = 1'b1;
    #1;
    chk("midrst_an", int'(an), 0);
    chk("midrst_seg", int'(seg), 0);
    chk("midrst_err", int'(err), 0);
    cyc();
    rst = 1'b0;
    cyc();
    chk("postrst_an", int'(an), 1);
    chk("postrst_seg", int'(seg), 'h3F);
    k = 0;
    while (an != 2'b10 && k < 100) begin cyc(); k++; end
    chk("postrst_tens", int'(seg), 'h3F);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst = 1'b1;
        cyc();
        rst = 1'b0;
      end
      load = ($urandom_range(0, 5) == 0);
      in0  = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
      in1  = ($urandom_range(0, 2) == 0) ? 4'd0 :
             (($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9)));
      flag = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 15) == 0) blank_lz = ~blank_lz;
      cyc();
    end
    load = 1'b0;
    cyc();
    check_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/bcd_display_mux.md
# bcd_display_mux

Two-digit multiplexed seven-segment driver placed directly downstream of the BCD adder. It captures the adder's tens digit, units digit and error flag on a load strobe, then time-multiplexes them onto one shared segment bus with a per-digit anode enable. It inserts a dead cycle between digits to avoid ghosting, and can optionally blank a leading zero. Any error, whether the flag or a non-BCD digit, is shown as a blinking "Er".

## Interface
- REFRESH_DIV, default 4: clock cycles each digit is lit (must be at least 1).
- BLINK_DIV, default 2: frames per blink half-period in error display (must be at least 1).
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- load  in  1  capture in0/in1/flag on this rising edge.
- in0  in  4  units BCD digit (adder out0).
- in1  in  4  tens BCD digit (adder out1).
- flag  in  1  adder error flag.
- blank_lz  in  1  level input; 1 blanks the tens digit when it is 0.
- seg  out  7  segments, active-high; seg[0]=a … seg[6]=g.
- an  out  2  one-hot digit enable, active-high; an[0]=units, an[1]=tens.
- err  out  1  captured error status.

## Operation
- Capture registers d0, d1 and e are cleared on reset and loaded when load=1.
  - e = flag | (in0>9) | (in1>9).
  - err = e.
- FSM states: S_UNITS, S_GAP0, S_TENS, S_GAP1. Cycle order: S_UNITS → S_GAP0 → S_TENS → S_GAP1 → S_UNITS.
- Refresh counter, width $clog2(REFRESH_DIV)+1:
  - Counts 0..REFRESH_DIV-1 in the S_UNITS and S_TENS states; the state advances at the terminal count.
  - Each GAP state lasts exactly 1 cycle; the counter is held at 0 there.
- Frame = one full loop = 2*REFRESH_DIV+2 cycles.
- Output decode (Moore, combinational from registers only):
  - GAP states: an=00, seg=0.
  - S_UNITS: an=01, seg=dec(d0).
  - S_TENS: an=10, seg=dec(d1). If blank_lz=1, d1=0 and e=0, then an=00 and seg=0 instead. Units are never blanked.
  - When e=1: S_TENS shows E (7'h79), S_UNITS shows r (7'h50). During the blink-off phase, an=00 and seg=0 in every state.
- Blink logic:
  - A frame counter increments on each S_GAP1→S_UNITS transition.
  - The blink phase toggles every BLINK_DIV frames and starts "on".
  - Frame counter and blink phase reset to 0/on on load and on rst.
- Decoder values, seg[6:0]:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - Codes A–F never display as digits; they force e.

## Timing
- Reset (asynchronous) sets:
  - state=S_GAP1, counters=0, d0=d1=0, e=0, blink phase=on.
  - Outputs therefore read seg=0, an=00, err=0 immediately, without waiting for a clock edge.
- The first cycle after rst deasserts is S_UNITS (an=01, seg=3F).
- Load latency: the captured values appear on err, and on seg in the current digit slot, 1 cycle after the load edge. The FSM position is unaffected by load.
- A load held high for several cycles recaptures on every edge; the last edge wins.
- Reset asserted mid-frame forces the reset outputs within the same cycle and aborts the frame.
- blank_lz is sampled combinationally, so it takes effect in the next S_TENS slot (or the current one).
- With REFRESH_DIV=1, the frame is 4 cycles.

## Structure
- Package bcd_pkg holds:
  - state encoding typedef (2-bit) with S_UNITS, S_GAP0, S_TENS, S_GAP1;
  - segment constants SEG_0..SEG_9, SEG_E, SEG_R, SEG_OFF.
- Sub-module bcd_to_seg7: purely combinational 4-bit → 7-bit decoder that outputs SEG_OFF for codes above 9. It is instantiated once, fed by a mux selecting d0 or d1.
- The top level contains the capture registers, refresh counter, FSM, blink counter and output override logic.

## Test plan
All scenarios use REFRESH_DIV=4 and BLINK_DIV=2.
- Reset: rst=1 → seg=00, an=00, err=0 with no clock edge; after release, cycle 1 → an=01, seg=3F.
- Load in1=1, in0=7, flag=0 → a 10-cycle frame: 4 cycles an=01/seg=07, 1 cycle an=00, 4 cycles an=10/seg=06, 1 cycle an=00; repeats.
- Load in1=0, in0=5 with blank_lz=1 → tens slot an=00, seg=00 and units seg=6D. Set blank_lz=0 → tens slot an=10, seg=3F.
- Load flag=1 → err=1; for 2 frames tens shows 79 and units shows 50; the next 2 frames have an=00 throughout; the pattern repeats. Load in0=4'hC with flag=0 → same error display.
- Assert rst during the S_TENS slot → an=00 and seg=00 immediately, with d0, d1 and err cleared. After release, the frame restarts at S_UNITS.
